quantize_pipe: RTL and testbench

Multi-lane, pipelined requantizer between the systolic-array accumulators and the output buffer. Converts LANES signed INPUT_DW-bit accumulator words to signed OUTPUT_DW-bit words using a runtime fractional shift, a selectable rounding mode and saturation, behind valid/ready handshakes. Successor to the fixed-format combinational quantizer: format, lane count and rounding are now configurable, and saturation events are flagged per lane and counted.

---
 rtl/quantize_pipe.sv | 130 +++++++++++++
 tb/tb_quantize_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/quantize_pipe.sv
// Multi-lane requantizer: arithmetic shift with optional round-half-away-from-zero,
// then saturation to OUTPUT_DW bits, as a two-stage valid/ready pipeline.
module quantize_pipe #(
    parameter int LANES     = 4,
    parameter int INPUT_DW  = 23,
    parameter int OUTPUT_DW = 8,
    parameter int SHIFT_W   = 5,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [SHIFT_W-1:0]             cfg_shift,
    input  logic                           cfg_round,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*INPUT_DW-1:0]      in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*OUTPUT_DW-1:0]     out_data,
    output logic [LANES-1:0]               out_sat,
    input  logic                           sat_clr,
    output logic [CNT_W-1:0]               sat_count
);

    localparam logic signed [INPUT_DW:0] MAX_POS = (INPUT_DW+1)'((1 << (OUTPUT_DW-1)) - 1);
    localparam logic signed [INPUT_DW:0] MIN_NEG = ~MAX_POS;

    // Negative values only round up when strictly past the half point, so ties go away from zero.
    function automatic logic signed [INPUT_DW:0] shift_round(
        input logic signed [INPUT_DW-1:0] x,
        input logic [SHIFT_W-1:0]         sh,
        input logic                       rnd
    );
        int                       s;
        logic signed [INPUT_DW-1:0] shifted;
        logic [INPUT_DW-1:0]      half_mask;
        logic [INPUT_DW-1:0]      low_mask;
        logic                     half;
        logic                     low;
        logic                     carry;
        s = int'(sh);
        if (s > INPUT_DW-1) s = INPUT_DW-1;
        shifted   = x >>> s;
        half_mask = (s == 0) ? '0 : (INPUT_DW'(1) << (s-1));
        low_mask  = half_mask - INPUT_DW'(1);
        half      = |(x & half_mask);
        low       = |(x & low_mask);
        carry     = rnd && (s > 0) && half && (!x[INPUT_DW-1] || low);
        return {shifted[INPUT_DW-1], shifted} + {{INPUT_DW{1'b0}}, carry};
    endfunction

    logic                       s1_valid;
    logic signed [INPUT_DW:0]   s1_r   [LANES];
    logic signed [INPUT_DW:0]   s1_nxt [LANES];
    logic [LANES*OUTPUT_DW-1:0] data_nxt;
    logic [LANES-1:0]           sat_nxt;
    logic [CNT_W:0]             pop;
    logic [CNT_W:0]             sum;
    logic                       s2_ready;
    logic                       s1_fire;
    logic                       s2_load;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign s1_fire  = in_valid && in_ready;
    assign s2_load  = s1_valid && s2_ready;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s1_nxt[i] = shift_round($signed(in_data[i*INPUT_DW +: INPUT_DW]), cfg_shift, cfg_round);
        end
    end

    always_comb begin
        data_nxt = '0;
        sat_nxt  = '0;
        pop      = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s1_r[i] > MAX_POS) begin
                data_nxt[i*OUTPUT_DW +: OUTPUT_DW] = MAX_POS[OUTPUT_DW-1:0];
                sat_nxt[i] = 1'b1;
            end else if (s1_r[i] < MIN_NEG) begin
                data_nxt[i*OUTPUT_DW +: OUTPUT_DW] = MIN_NEG[OUTPUT_DW-1:0];
                sat_nxt[i] = 1'b1;
            end else begin
                data_nxt[i*OUTPUT_DW +: OUTPUT_DW] = s1_r[i][OUTPUT_DW-1:0];
            end
            pop = pop + {{CNT_W{1'b0}}, sat_nxt[i]};
        end
        sum = {1'b0, sat_count} + pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) s1_r[i] <= '0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (s1_fire) begin
                for (int i = 0; i < LANES; i++) s1_r[i] <= s1_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else begin
            if (s2_ready) out_valid <= s1_valid;
            if (s2_load) begin
                out_data <= data_nxt;
                out_sat  <= sat_nxt;
            end
        end
    end

    // A clear in the same cycle as a transfer keeps only that beat's contribution.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= s2_load ? pop[CNT_W-1:0] : '0;
        end else if (s2_load) begin
            sat_count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_quantize_pipe.sv
// Scoreboard bench for quantize_pipe: directed beats, random stream with backpressure,
// saturation counter clamp/clear and mid-stream reset.
module tb_quantize_pipe;
    localparam int LANES = 4;
    localparam int IDW   = 23;
    localparam int ODW   = 8;
    localparam int SW    = 5;
    localparam int CW    = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [SW-1:0]          cfg_shift = '0;
    logic                   cfg_round = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [LANES*IDW-1:0]   in_data = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [LANES*ODW-1:0]   out_data;
    logic [LANES-1:0]       out_sat;
    logic                   sat_clr = 1'b0;
    logic [CW-1:0]          sat_count;

    always #5 clk = ~clk;

    quantize_pipe #(.LANES(LANES), .INPUT_DW(IDW), .OUTPUT_DW(ODW), .SHIFT_W(SW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_shift(cfg_shift), .cfg_round(cfg_round),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .sat_clr(sat_clr), .sat_count(sat_count)
    );

    typedef struct {
        logic [LANES*ODW-1:0] d;
        logic [LANES-1:0]     s;
        int                   acc;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_low = -1;
    int acc_cnt = 0;
    int out_cnt = 0;
    int model_cnt = 0;
    bit rnd_done = 0;
    logic held = 1'b0;
    logic [LANES*ODW-1:0] held_d;
    logic [LANES-1:0] held_s;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ODW:0] model_lane(input longint x, input int sh, input bit rnd);
        longint d, q, rem;
        int s;
        s = (sh > IDW-1) ? IDW-1 : sh;
        d = longint'(1) << s;
        q = x / d;
        if ((x % d) != 0 && x < 0) q = q - 1;
        rem = x - q * d;
        if (rnd && s > 0) begin
            if (x >= 0 && 2*rem >= d) q = q + 1;
            else if (x < 0 && 2*rem > d) q = q + 1;
        end
        if (q > (longint'(1) << (ODW-1)) - 1) return {1'b1, 1'b0, {(ODW-1){1'b1}}};
        if (q < -(longint'(1) << (ODW-1)))    return {1'b1, 1'b1, {(ODW-1){1'b0}}};
        return {1'b0, q[ODW-1:0]};
    endfunction

    function automatic logic [LANES*IDW-1:0] pack(input int a, input int b, input int c, input int d);
        return {IDW'(d), IDW'(c), IDW'(b), IDW'(a)};
    endfunction

    task automatic send(input logic [LANES*IDW-1:0] data, input int sh, input bit rnd,
                        input bit use_exp, input logic [LANES*ODW-1:0] ed, input logic [LANES-1:0] es);
        exp_t e;
        logic [ODW:0] l;
        bit done;
        done = 0;
        cfg_shift = SW'(sh);
        cfg_round = rnd;
        in_data   = data;
        in_valid  = 1'b1;
        if (use_exp) begin
            e.d = ed;
            e.s = es;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                l = model_lane(longint'($signed(data[i*IDW +: IDW])), sh, rnd);
                e.d[i*ODW +: ODW] = l[ODW-1:0];
                e.s[i] = l[ODW];
            end
        end
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.acc = cyc;
                sb.push_back(e);
                model_cnt = model_cnt + $countones(e.s);
                if (model_cnt > 65535) model_cnt = 65535;
                done = 1;
            end
            @(posedge clk); #1;
        end
        check("send_accept", 64'(done), 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        in_valid = 1'b0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) ok = 1;
        end
        @(posedge clk); #1;
        check("drain", 64'(ok), 64'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (!out_ready) last_low = cyc;
            check("in_ready", 64'(in_ready), 64'(((acc_cnt - out_cnt) < 2) || out_ready));
            if (held) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", {out_sat, out_data}, {held_s, held_d});
            end
            if (out_valid && out_ready) begin
                check("out_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("out_data", 64'(out_data), 64'(e.d));
                    check("out_sat", 64'(out_sat), 64'(e.s));
                    if (last_low < e.acc) check("latency", 64'(cyc - e.acc), 64'd2);
                end
                out_cnt++;
            end
            held   = out_valid && !out_ready;
            held_d = out_data;
            held_s = out_sat;
            if (in_valid && in_ready) acc_cnt++;
        end
    end

    initial begin
        logic [LANES*IDW-1:0] rdata;
        logic [IDW-1:0] v;
        int burst;

        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_sat_count", 64'(sat_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        send(pack(20, -20, -21, 19), 3, 1, 1, 32'h02FDFD03, 4'b0000);
        send(pack(20, -20, -21, 19), 3, 0, 1, 32'h02FDFD02, 4'b0000);
        send(pack(2000, -2000, 1019, -1028), 3, 1, 1, 32'h807F807F, 4'b1011);
        drain();
        check("sat_count_directed", 64'(sat_count), 64'd3);

        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    for (int i = 0; i < LANES; i++) begin
                        if ($urandom_range(0, 1) == 0) v = IDW'($urandom);
                        else v = IDW'(int'($urandom_range(0, 4000)) - 2000);
                        rdata[i*IDW +: IDW] = v;
                    end
                    send(rdata, int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)), 0, '0, '0);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                rnd_done = 1;
            end
            begin
                burst = 0;
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    if (burst > 0) begin
                        burst--;
                        out_ready = 1'b0;
                    end else if ($urandom_range(0, 9) == 0) begin
                        burst = 4;
                        out_ready = 1'b0;
                    end else begin
                        out_ready = ($urandom_range(0, 9) > 3);
                    end
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("sat_count_random", 64'(sat_count), 64'(model_cnt));

        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        model_cnt = 0;
        check("sat_clr_idle", 64'(sat_count), 64'd0);

        for (int n = 0; n < 16383; n++)
            send(pack(32'h3FFFFF, -32'h3FFFFF, 32'h3FFFFF, -32'h3FFFFF), 0, 0, 0, '0, '0);
        drain();
        check("sat_count_preload", 64'(sat_count), 64'd65532);
        send(pack(32'h3FFFFF, -32'h3FFFFF, 32'h3FFFFF, -32'h3FFFFF), 0, 1, 0, '0, '0);
        send(pack(32'h3FFFFF, -32'h3FFFFF, 32'h3FFFFF, -32'h3FFFFF), 5, 0, 0, '0, '0);
        drain();
        check("sat_count_clamp", 64'(sat_count), 64'd65535);

        send(pack(2000, -2000, 5, 5), 3, 1, 0, '0, '0);
        in_valid = 1'b0;
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        model_cnt = 2;
        drain();
        check("sat_clr_coincident", 64'(sat_count), 64'(model_cnt));

        out_ready = 1'b0;
        send(pack(32'h3FFFFF, -32'h3FFFFF, 100, -100), 0, 0, 0, '0, '0);
        send(pack(7, 8, 9, 10), 1, 1, 0, '0, '0);
        idle(1);
        check("full_in_ready", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        check("mid_rst_out_sat", 64'(out_sat), 64'd0);
        check("mid_rst_sat_count", 64'(sat_count), 64'd0);
        sb.delete();
        acc_cnt = 0;
        out_cnt = 0;
        model_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(pack(20, -20, -21, 19), 3, 1, 1, 32'h02FDFD03, 4'b0000);
        drain();
        check("post_rst_sat_count", 64'(sat_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
